// File: rtl/fft_stream_pkg.sv
// -----------------------------------------------------------------------------
// fft_stream_pkg
//   Shared types and helpers for the FFT frame streamer.
//   - state_t      : framer FSM states (IDLE, STREAM, PAD, DONE)
//   - FFT_WORD_W   : complex FFT word width for the default 16-bit halves
//   - pack_sample(): builds the complex FFT input word from one audio sample
// -----------------------------------------------------------------------------
package fft_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PAD    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W = 16;
    localparam int FFT_WORD_W     = 2 * DEFAULT_DATA_W;

    // Widest half-word the helper supports; callers truncate the result.
    localparam int PACK_MAX_W = 64;

    // Real half = sample left-justified in data_w bits, imaginary half = 0.
    // The result holds the real half in bits [data_w-1:0] and zeros above it,
    // so taking the low 2*data_w bits gives {imag, real}. Left-justifying
    // keeps the two's-complement sign bit at the top of the real half.
    // The sample must be zero-extended into the argument.
    function automatic logic [2*PACK_MAX_W-1:0] pack_sample(
        input logic [PACK_MAX_W-1:0] sample,
        input int                    sample_w,
        input int                    data_w
    );
        logic [PACK_MAX_W-1:0] re;
        re = sample << (data_w - sample_w);
        return {{PACK_MAX_W{1'b0}}, re};
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
//   Single-entry AXI-stream output register. A loaded beat is held stable
//   (data, valid, last) until the downstream handshake.
//   Handshake: a beat transfers on a rising clk edge where tvalid && tready;
//   the producer may assert load only when can_load is high.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             write load_data/load_last into the register this cycle
//   load_data/last   beat payload and end-of-frame flag
//   tready           downstream ready
//   can_load         register is empty or is being emptied this cycle
//   tvalid/tdata/tlast  registered AXI-stream outputs
// -----------------------------------------------------------------------------
module axis_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         tready,
    output logic         can_load,
    output logic         tvalid,
    output logic [W-1:0] tdata,
    output logic         tlast
);

    assign can_load = !tvalid || tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_frame_streamer.sv
// -----------------------------------------------------------------------------
// fft_frame_streamer
//   Frames signed audio samples into complex FFT input words, asserting tlast
//   every FRAME_LEN beats. Emits 'frames_in' frames per run (0 = until the
//   recording's final sample) and closes a partial final frame.
//   Build option FRAME_ZERO_PAD_EN:
//     defined   - a mid-frame final sample is followed by zero beats up to a
//                 full frame.
//     undefined - the mid-frame final sample carries tlast (short frame) and
//                 the sticky short_frame_out flag is set.
//   Handshake (both sides): a transfer happens on a rising clk_in edge where
//   valid && ready; a valid beat holds its payload until transferred.
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   start_in, frames_in   run start pulse and frame limit (sampled on start)
//   s_valid_in/s_data_in/s_last_in/s_ready_out   sample input stream
//   m_tdata_out/m_tvalid_out/m_tlast_out/m_tready_in   FFT output stream
//   frame_count_out       frames whose tlast beat was accepted this run
//   busy_out, done_out    not-idle flag, run-complete pulse
//   state_out             FSM state for debug/observation
//   short_frame_out       sticky short-frame flag (only without zero padding)
// -----------------------------------------------------------------------------
module fft_frame_streamer
    import fft_stream_pkg::*;
#(
    parameter int SAMPLE_W    = 8,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int FRAME_LEN   = 2048,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [FRAME_CNT_W-1:0] frames_in,
    input  logic                   s_valid_in,
    input  logic [SAMPLE_W-1:0]    s_data_in,
    input  logic                   s_last_in,
    output logic                   s_ready_out,
    output logic [2*DATA_W-1:0]    m_tdata_out,
    output logic                   m_tvalid_out,
    output logic                   m_tlast_out,
    input  logic                   m_tready_in,
    output logic [FRAME_CNT_W-1:0] frame_count_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [1:0]             state_out
`ifndef FRAME_ZERO_PAD_EN
    ,
    output logic                   short_frame_out
`endif
);

    localparam int WORD_W = 2 * DATA_W;
    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [FRAME_CNT_W-1:0] limit_q;
    logic [FRAME_CNT_W-1:0] count_q;
    // Set once the run's final beat sits in the output register; input is
    // closed and we only wait for that beat's handshake.
    logic                   drain_q;

    logic              can_load;
    logic              load;
    logic [WORD_W-1:0] load_word;
    logic              load_last;
    logic              load_final;
    logic              idx_last;
    logic              limit_hit;
    logic              tlast_hs;
    logic [WORD_W-1:0] sample_word;

`ifndef FRAME_ZERO_PAD_EN
    logic short_q;
    logic short_set;
    assign short_frame_out = short_q;
`endif

    assign sample_word = WORD_W'(pack_sample(PACK_MAX_W'(s_data_in), SAMPLE_W, DATA_W));
    assign idx_last    = (idx_q == IDX_LAST);
    // Frames before the current one are all accepted by the time its last
    // beat is loaded, so count_q is the index of the frame being built.
    assign limit_hit   = (limit_q != '0) && (count_q == limit_q - FRAME_CNT_W'(1));
    assign tlast_hs    = m_tvalid_out && m_tready_in && m_tlast_out;

    assign s_ready_out     = (state_q == STREAM) && !drain_q && can_load;
    assign busy_out        = (state_q != IDLE);
    assign done_out        = (state_q == DONE);
    assign frame_count_out = count_q;
    assign state_out       = state_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_word  = '0;
        load_last  = 1'b0;
        load_final = 1'b0;
`ifndef FRAME_ZERO_PAD_EN
        short_set  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_in) state_d = STREAM;
            end
            STREAM: begin
                if (s_ready_out && s_valid_in) begin
                    load      = 1'b1;
                    load_word = sample_word;
`ifdef FRAME_ZERO_PAD_EN
                    load_last  = idx_last;
                    load_final = idx_last && (s_last_in || limit_hit);
                    if (s_last_in && !idx_last) state_d = PAD;
`else
                    load_last  = idx_last || s_last_in;
                    load_final = s_last_in || (idx_last && limit_hit);
                    short_set  = s_last_in && !idx_last;
`endif
                end
                if (drain_q && tlast_hs) state_d = DONE;
            end
            PAD: begin
                // Zero beats up to the frame end; that beat always ends the run.
                if (!drain_q && can_load) begin
                    load       = 1'b1;
                    load_last  = idx_last;
                    load_final = idx_last;
                end
                if (drain_q && tlast_hs) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_q   <= '0;
            limit_q <= '0;
            count_q <= '0;
            drain_q <= 1'b0;
`ifndef FRAME_ZERO_PAD_EN
            short_q <= 1'b0;
`endif
        end else if (state_q == IDLE && start_in) begin
            idx_q   <= '0;
            limit_q <= frames_in;
            count_q <= '0;
            drain_q <= 1'b0;
`ifndef FRAME_ZERO_PAD_EN
            short_q <= 1'b0;
`endif
        end else begin
            if (load) begin
                idx_q <= idx_q + IDX_W'(1);
                if (load_final) drain_q <= 1'b1;
            end
            if (tlast_hs) count_q <= count_q + FRAME_CNT_W'(1);
`ifndef FRAME_ZERO_PAD_EN
            if (short_set) short_q <= 1'b1;
`endif
        end
    end

    axis_out_reg #(.W(WORD_W)) u_out_reg (
        .clk       (clk_in),
        .rst       (rst_in),
        .load      (load),
        .load_data (load_word),
        .load_last (load_last),
        .tready    (m_tready_in),
        .can_load  (can_load),
        .tvalid    (m_tvalid_out),
        .tdata     (m_tdata_out),
        .tlast     (m_tlast_out)
    );

endmodule

// File: tb/tb_fft_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_streamer
//   Directed bench for fft_frame_streamer with FRAME_LEN=8, SAMPLE_W=8,
//   DATA_W=16. Honours FRAME_ZERO_PAD_EN for the expected results.
// -----------------------------------------------------------------------------
module tb_fft_frame_streamer;

  localparam int SAMPLE_W    = 8;
  localparam int DATA_W      = 16;
  localparam int FRAME_LEN   = 8;
  localparam int FRAME_CNT_W = 16;
  localparam int NCASES      = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_in;
  logic                   start_in;
  logic [FRAME_CNT_W-1:0] frames_in;
  logic                   s_valid_in;
  logic [SAMPLE_W-1:0]    s_data_in;
  logic                   s_last_in;
  logic                   s_ready_out;
  logic [2*DATA_W-1:0]    m_tdata_out;
  logic                   m_tvalid_out;
  logic                   m_tlast_out;
  logic                   m_tready_in;
  logic [FRAME_CNT_W-1:0] frame_count_out;
  logic                   busy_out;
  logic                   done_out;
  logic [1:0]             state_out;
`ifndef FRAME_ZERO_PAD_EN
  logic                   short_frame_out;
`endif

  fft_frame_streamer #(
    .SAMPLE_W(SAMPLE_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .FRAME_CNT_W(FRAME_CNT_W)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .frames_in       (frames_in),
    .s_valid_in      (s_valid_in),
    .s_data_in       (s_data_in),
    .s_last_in       (s_last_in),
    .s_ready_out     (s_ready_out),
    .m_tdata_out     (m_tdata_out),
    .m_tvalid_out    (m_tvalid_out),
    .m_tlast_out     (m_tlast_out),
    .m_tready_in     (m_tready_in),
    .frame_count_out (frame_count_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .state_out       (state_out)
`ifndef FRAME_ZERO_PAD_EN
    ,
    .short_frame_out (short_frame_out)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];   // {tlast, tdata}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] samp(input int i);
    if (i == 9) return 8'h80;
    return 8'(i * 5 + 3);
  endfunction

  typedef struct {
    logic [15:0] frames;
    int          n_samples;
    int          last_at;      // -1: no s_last_in
    bit          toggle;       // m_tready_in 1-0-1-0
    bit          poke;         // pulse start_in mid-run with a new frames_in
    int          exp_beats;
    int          exp_frames;
    int          exp_consumed;
    bit          exp_short;
  } case_t;

  case_t cases[NCASES];

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    start_in   = 1'b0;
    s_valid_in = 1'b0;
    s_data_in  = '0;
    s_last_in  = 1'b0;
    m_tready_in = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, 64'(m_tvalid_out), 64'd0);
    check({tag, "_tdata"},  64'(m_tdata_out), 64'd0);
    check({tag, "_tlast"},  64'(m_tlast_out), 64'd0);
    check({tag, "_s_ready"}, 64'(s_ready_out), 64'd0);
    check({tag, "_frame_count"}, 64'(frame_count_out), 64'd0);
    check({tag, "_busy"}, 64'(busy_out), 64'd0);
    check({tag, "_done"}, 64'(done_out), 64'd0);
    check({tag, "_state"}, 64'(state_out), 64'd0);
`ifndef FRAME_ZERO_PAD_EN
    check({tag, "_short"}, 64'(short_frame_out), 64'd0);
`endif
  endtask

  // Called at posedge+1. Starts a run, drives samples, checks each beat.
  task automatic run_case(input int id, input case_t tc);
    int sent, done_pulses, after_done, beats;
    bit prev_stall;
    bit l;
    logic [32:0] prev_beat, act, exp;
    string tag;
    tag = $sformatf("c%0d", id);

    exp_q.delete();
    for (int i = 0; i < tc.exp_consumed; i++) begin
      l = (i % FRAME_LEN == FRAME_LEN - 1);
`ifndef FRAME_ZERO_PAD_EN
      if (i == tc.last_at) l = 1'b1;
`endif
      exp_q.push_back({l, 16'h0000, samp(i), 8'h00});
    end
`ifdef FRAME_ZERO_PAD_EN
    for (int i = tc.exp_consumed; i % FRAME_LEN != 0; i++)
      exp_q.push_back({(i % FRAME_LEN == FRAME_LEN - 1), 32'h0});
`endif

    frames_in = tc.frames;
    start_in  = 1'b1;
    @(posedge clk); #1;
    start_in  = 1'b0;
    frames_in = 16'hffff;
    @(negedge clk);
    check({tag, "_busy_after_start"}, 64'(busy_out), 64'd1);
    @(posedge clk); #1;

    sent = 0; done_pulses = 0; after_done = 0; beats = 0;
    prev_stall = 1'b0; prev_beat = '0;
    for (int cyc = 0; cyc < 300 && after_done < 4; cyc++) begin
      s_valid_in  = (sent < tc.n_samples);
      s_data_in   = samp(sent);
      s_last_in   = (sent == tc.last_at);
      m_tready_in = tc.toggle ? (cyc % 2 == 0) : 1'b1;
      if (tc.poke && cyc == 3) begin
        start_in  = 1'b1;
        frames_in = 16'd5;
      end else begin
        start_in  = 1'b0;
      end
      @(negedge clk);
      act = {m_tlast_out, m_tdata_out};
      if (prev_stall) begin
        check({tag, "_hold_valid"}, 64'(m_tvalid_out), 64'd1);
        check({tag, "_hold_beat"}, 64'(act), 64'(prev_beat));
      end
      prev_stall = m_tvalid_out && !m_tready_in;
      prev_beat  = act;
      if (prev_stall) check({tag, "_stall_s_ready"}, 64'(s_ready_out), 64'd0);
      if (s_valid_in && s_ready_out) sent++;
      if (m_tvalid_out && m_tready_in) begin
        beats++;
        if (exp_q.size() == 0) begin
          check({tag, "_beat_overrun"}, 64'(beats), 64'(tc.exp_beats));
        end else begin
          exp = exp_q.pop_front();
          check($sformatf("%s_beat%0d", tag, beats - 1), 64'(act), 64'(exp));
        end
      end
      if (done_out) done_pulses++;
      if (done_pulses > 0) after_done++;
      @(posedge clk); #1;
    end
    idle_inputs();

    check({tag, "_done_pulses"}, 64'(done_pulses), 64'd1);
    check({tag, "_beats"}, 64'(beats), 64'(tc.exp_beats));
    check({tag, "_consumed"}, 64'(sent), 64'(tc.exp_consumed));
    check({tag, "_frame_count"}, 64'(frame_count_out), 64'(tc.exp_frames));
    check({tag, "_busy_end"}, 64'(busy_out), 64'd0);
    check({tag, "_missing_beats"}, 64'(exp_q.size()), 64'd0);
`ifndef FRAME_ZERO_PAD_EN
    check({tag, "_short"}, 64'(short_frame_out), 64'(tc.exp_short));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sent;

    //            frames n  last tog poke beats frames cons short
    cases[0] = '{16'd2, 16, -1, 0, 0, 16, 2, 16, 0};
    cases[1] = '{16'd2, 16, -1, 1, 0, 16, 2, 16, 0};
    cases[2] = '{16'd1, 12, -1, 0, 0,  8, 1,  8, 0};
`ifdef FRAME_ZERO_PAD_EN
    cases[3] = '{16'd0,  6,  5, 0, 0,  8, 1,  6, 0};
    cases[7] = '{16'd0, 11, 10, 1, 0, 16, 2, 11, 0};
`else
    cases[3] = '{16'd0,  6,  5, 0, 0,  6, 1,  6, 1};
    cases[7] = '{16'd0, 11, 10, 1, 0, 11, 2, 11, 1};
`endif
    cases[4] = '{16'd0,  8,  7, 1, 0,  8, 1,  8, 0};
    cases[5] = '{16'd2, 16, 15, 0, 0, 16, 2, 16, 0};
    cases[6] = '{16'd1, 12, -1, 0, 1,  8, 1,  8, 0};

    idle_inputs();
    frames_in = '0;
    rst_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_in = 1'b0;

    // Reset in the middle of frame 0, while beat 3 is held and sample 4 offered.
    frames_in = 16'd0;
    start_in  = 1'b1;
    @(posedge clk); #1;
    start_in  = 1'b0;
    sent = 0;
    for (int c = 0; c < 40 && sent < 4; c++) begin
      s_valid_in = 1'b1;
      s_data_in  = samp(sent);
      s_last_in  = 1'b0;
      @(negedge clk);
      if (s_valid_in && s_ready_out) sent++;
      @(posedge clk); #1;
    end
    check("midrun_pre_consumed", 64'(sent), 64'd4);
    s_data_in = samp(4);
    rst_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrun_reset");
    @(posedge clk); #1;
    rst_in = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_reset_done", 64'(done_out), 64'd0);
      check("post_reset_busy", 64'(busy_out), 64'd0);
      @(posedge clk); #1;
    end

    // Table: case 0 also confirms the sample index restarted at 0 after reset.
    for (int k = 0; k < NCASES; k++) begin
      run_case(k, cases[k]);
      repeat (2) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
